// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch path: reset/trap vectors,
// the NOP word and the next-PC source selector.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_JR     = 3'd2,
    PC_BRANCH = 3'd3,
    PC_ILLOP  = 3'd4,
    PC_XADR   = 3'd5
  } pc_sel_e;

  // Register-sourced targets may carry junk in the low bits; fetch is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction ROM bus: the fetch stage drives the byte address, the ROM
// answers combinationally in the same cycle.
interface if_stage_if;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority encoder and target mux:
// exception > interrupt > branch > jr > jump > sequential.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] ILLOP_ADDR = ILLOP_VEC,
  parameter logic [31:0] XADR_ADDR  = XADR_VEC
) (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jump_target,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        irq_take,
  input  logic        exception,
  output pc_sel_e     sel,
  output logic [31:0] next_pc
);

  always_comb begin
    sel = PC_SEQ;
    if (exception)         sel = PC_XADR;
    else if (irq_take)     sel = PC_ILLOP;
    else if (branch_taken) sel = PC_BRANCH;
    else if (jr)           sel = PC_JR;
    else if (jump)         sel = PC_JUMP;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_XADR:   next_pc = XADR_ADDR;
      PC_ILLOP:  next_pc = ILLOP_ADDR;
      PC_BRANCH: next_pc = align_word(branch_target);
      PC_JR:     next_pc = align_word(jr_target);
      PC_JUMP:   next_pc = jump_target;
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, ROM addressing and the IF/ID
// pipeline register, with stall/flush and redirect handling.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC,
  parameter logic [31:0] ILLOP_ADDR = ILLOP_VEC,
  parameter logic [31:0] XADR_ADDR  = XADR_VEC,
  parameter logic [31:0] NOP_INSTR  = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  rom,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        irq,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output pc_sel_e     pc_sel
);

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] next_pc;
  logic        irq_take;
  logic        redirect;
  logic        squash;

  assign rom.rom_addr = pc;

  // The supervisor bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign pc_plus4    = {pc[31], pc[30:0] + 31'd4};
  assign jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
  assign irq_take    = irq & ~pc[31];

  next_pc_sel #(
    .ILLOP_ADDR (ILLOP_ADDR),
    .XADR_ADDR  (XADR_ADDR)
  ) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .jump_target   (jump_target),
    .jump          (jump),
    .jr            (jr),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .irq_take      (irq_take),
    .exception     (exception),
    .sel           (pc_sel),
    .next_pc       (next_pc)
  );

  // Any redirect beats stall for the PC; jump/jr alone leave IF/ID to the flush input.
  assign redirect = (pc_sel != PC_SEQ);
  assign squash   = flush | exception | irq_take | branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_ADDR;
    end else if (redirect || !stall) begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= RESET_ADDR;
      if_id_valid    <= 1'b0;
    end else if (squash) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_instr    <= rom.rom_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch/stall/redirect/reset
// scenarios plus a random control phase, scored against a reference model.
module tb_if_stage;
  import mips_pkg::*;

  localparam int W = 97;

  logic        clk;
  logic        reset;
  logic        stall, flush, jump, jr, branch_taken, irq, exception;
  logic [31:0] jr_target, branch_target;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;
  pc_sel_e     pc_sel;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .rom            (bus.master),
    .stall          (stall),
    .flush          (flush),
    .jump           (jump),
    .jr             (jr),
    .jr_target      (jr_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .irq            (irq),
    .exception      (exception),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .pc_sel         (pc_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0011;
      32'h8000_0004: return 32'h0000_0022;
      32'h8000_0008: return 32'h0000_0033;
      32'h0000_0200: return 32'h0800_0010;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb bus.rom_data = rom_fn(bus.rom_addr);

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_WORD; m_pc4 = RESET_PC; m_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; jump = 0; jr = 0; branch_taken = 0; irq = 0; exception = 0;
    jr_target = 32'h0; branch_target = 32'h0;
  endtask

  // drive one cycle at negedge, predict, then compare after the rising edge
  task automatic step(input logic s, input logic f, input logic j, input logic r,
                      input logic [31:0] rt, input logic b, input logic [31:0] bt,
                      input logic q, input logic e);
    logic [31:0] p4, jt, npc;
    logic        it, sq;
    logic [W-1:0] got, want;
    @(negedge clk);
    stall = s; flush = f; jump = j; jr = r; jr_target = rt;
    branch_taken = b; branch_target = bt; irq = q; exception = e;
    p4 = {m_pc[31], m_pc[30:0] + 31'd4};
    jt = {m_pc4[31:28], m_instr[25:0], 2'b00};
    it = q && !m_pc[31];
    if (e)       npc = XADR_VEC;
    else if (it) npc = ILLOP_VEC;
    else if (b)  npc = {bt[31:2], 2'b00};
    else if (r)  npc = {rt[31:2], 2'b00};
    else if (j)  npc = jt;
    else if (s)  npc = m_pc;
    else         npc = p4;
    sq = f || e || it || b;
    #1;
    check_eq("rom_addr", bus.rom_addr, m_pc);
    if (sq) begin
      m_instr = NOP_WORD; m_pc4 = p4; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = rom_fn(m_pc); m_pc4 = p4; m_valid = 1'b1;
    end
    m_pc = npc;
    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid});
    @(posedge clk);
    #1;
    got  = {pc, if_id_instr, if_id_pc_plus4, if_id_valid};
    want = exp_q.pop_front();
    check_eq("pc",    got[96:65], want[96:65]);
    check_eq("instr", got[64:33], want[64:33]);
    check_eq("pc4",   got[32:1],  want[32:1]);
    check_eq("valid", {31'd0, got[0]}, {31'd0, want[0]});
    idle_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    check_eq("rst_pc",    pc, RESET_PC);
    check_eq("rst_instr", if_id_instr, NOP_WORD);
    check_eq("rst_pc4",   if_id_pc_plus4, RESET_PC);
    check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("rst_addr",  bus.rom_addr, RESET_PC);
    @(posedge clk);
    #2 reset = 1'b1;

    // free run from reset vector
    run(1);
    check_eq("run1_instr", if_id_instr, 32'h11);
    run(1);
    check_eq("run2_instr", if_id_instr, 32'h22);
    check_eq("run2_pc",    pc, 32'h8000_0008);

    // two-cycle stall then resume
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    check_eq("stall_pc", pc, 32'h8000_0008);
    run(1);
    check_eq("resume_pc",    pc, 32'h8000_000C);
    check_eq("resume_instr", if_id_instr, 32'h33);

    // branch overrides stall, squashes IF/ID, target aligned
    step(1, 0, 0, 0, 32'h0, 1, 32'h8000_0041, 0, 0);
    check_eq("br_pc",    pc, 32'h8000_0040);
    check_eq("br_valid", {31'd0, if_id_valid}, 32'd0);

    // irq taken in user mode
    step(0, 0, 0, 1, 32'h0000_0101, 0, 32'h0, 0, 0);
    check_eq("jr_pc", pc, 32'h0000_0100);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    check_eq("irq_pc", pc, 32'h8000_0004);

    // irq masked in supervisor mode
    step(0, 0, 0, 1, 32'h8000_0100, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    check_eq("irq_mask_pc", pc, 32'h8000_0104);

    // exception beats irq and jump
    step(0, 0, 0, 1, 32'h0000_0300, 0, 32'h0, 0, 0);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 1, 1);
    check_eq("exc_pc", pc, 32'h8000_0008);

    // jump target from IF/ID fields
    step(0, 0, 0, 1, 32'h0000_0200, 0, 32'h0, 0, 0);
    run(1);
    check_eq("j_instr", if_id_instr, 32'h0800_0010);
    check_eq("j_pc4",   if_id_pc_plus4, 32'h0000_0204);
    step(0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    check_eq("j_pc", pc, 32'h0000_0040);

    // flush together with stall: flush wins on IF/ID, PC holds
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);

    // random control mix
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    // asynchronous reset between edges
    step(0, 0, 0, 1, 32'h8000_0020, 0, 32'h0, 0, 0);
    check_eq("pre_rst_pc", pc, 32'h8000_0020);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_pc",    pc, RESET_PC);
    check_eq("arst_instr", if_id_instr, NOP_WORD);
    check_eq("arst_valid", {31'd0, if_id_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    run(2);
    check_eq("post_rst_instr", if_id_instr, 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
